// File: rtl/ld_port_mem.sv
// ld_port_mem: preloadable RAM that serves one handshake load port.
// Load addresses are accepted over a valid/ready channel. Read data comes back
// in order through a 2-entry output FIFO, so the consumer can apply backpressure.
// Optional feature macro: LD_PORT_MEM_STATS_EN adds the ld_count and stall_count
// statistics ports.
module ld_port_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_addr_valid,
    output logic              ld_addr_ready,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_data_valid,
    input  logic              ld_data_ready,
    output logic              err
`ifdef LD_PORT_MEM_STATS_EN
    ,
    output logic [15:0]       ld_count,
    output logic [15:0]       stall_count
`endif
);

    // DEPTH widened by one bit so that DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_fifo [2];
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_count;
    logic              r_err;

    logic              w_wrInRange;
    logic              w_ldInRange;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_readData;

    assign w_wrInRange   = ({1'b0, wr_addr} < DEPTH_EXT);
    assign w_ldInRange   = ({1'b0, ld_addr} < DEPTH_EXT);

    // Ready depends only on reset and the registered count, never on ld_data_ready.
    assign ld_addr_ready = !reset && (r_count != 2'd2);
    assign ld_data_valid = (r_count != 2'd0);
    assign ld_data       = (r_count != 2'd0) ? r_fifo[r_rdPtr] : '0;
    assign err           = r_err;

    assign w_push        = ld_addr_valid && ld_addr_ready;
    assign w_pop         = ld_data_valid && ld_data_ready;

    // Read value: out-of-range loads return zero; a same-cycle write to the same address is forwarded.
    always_comb begin
        w_readData = '0;
        if (!w_ldInRange) begin
            w_readData = '0;
        end else if (wr_en && (wr_addr == ld_addr)) begin
            w_readData = wr_data;
        end else begin
            w_readData = r_mem[ld_addr[IDX_W-1:0]];
        end
    end

    // Preload storage: it has no reset, so its contents survive a reset. Out-of-range writes are dropped.
    always_ff @(posedge clock) begin
        if (wr_en && w_wrInRange) begin
            r_mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // FIFO data slots: written on push only, with no reset, because an empty FIFO outputs zero anyway.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_fifo[r_wrPtr] <= w_readData;
        end
    end

    // FIFO pointers, occupancy count and the sticky out-of-range flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= ~r_wrPtr;
                if (!w_ldInRange) begin
                    r_err <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef LD_PORT_MEM_STATS_EN
    logic [15:0] r_ldCount;
    logic [15:0] r_stallCount;

    assign ld_count    = r_ldCount;
    assign stall_count = r_stallCount;

    // Saturating counters for accepted loads and for cycles where the consumer stalls the head entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ldCount    <= 16'd0;
            r_stallCount <= 16'd0;
        end else begin
            if (w_push && (r_ldCount != 16'hFFFF)) begin
                r_ldCount <= r_ldCount + 16'd1;
            end
            if (ld_data_valid && !ld_data_ready && (r_stallCount != 16'hFFFF)) begin
                r_stallCount <= r_stallCount + 16'd1;
            end
        end
    end
`endif

endmodule
